// File: rtl/alu_seq.sv
// Registered multi-cycle ALU: single-cycle logic/arith ops plus iterative
// unsigned MULTU/DIVU into HI/LO, with a start/busy/done handshake.
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 6
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             start,
    input  logic [3:0]       ALUop,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_MULT = 4'b1000;
    localparam logic [3:0] OP_DIV  = 4'b1001;
    localparam logic [3:0] OP_MFHI = 4'b1010;
    localparam logic [3:0] OP_MFLO = 4'b1011;

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t           state, state_nx;
    logic [CNTW-1:0]  cnt, cnt_nx;
    logic [WIDTH-1:0] acc, acc_nx;   // MUL: product upper half; DIV: partial remainder
    logic [WIDTH-1:0] qr, qr_nx;     // MUL: multiplier/product lower half; DIV: dividend/quotient
    logic [WIDTH-1:0] dvs, dvs_nx;   // MUL: multiplicand; DIV: divisor
    logic [WIDTH-1:0] result_nx, hi_nx, lo_nx;
    logic             zero_nx, done_nx, last;
    logic [WIDTH-1:0] alu_out;
    logic [WIDTH:0]   mul_sum, div_sh, div_diff;

    assign busy = (state != IDLE);
    assign last = (cnt == CNTW'(WIDTH - 1));

    always_comb begin
        alu_out = '0;
        case (ALUop)
            OP_AND:  alu_out = opA & opB;
            OP_OR:   alu_out = opA | opB;
            OP_ADD:  alu_out = opA + opB;
            OP_SUB:  alu_out = opA - opB;
            OP_SLT:  alu_out = {{(WIDTH-1){1'b0}}, ($signed(opA) < $signed(opB))};
            OP_NOR:  alu_out = ~(opA | opB);
            OP_MFHI: alu_out = hi;
            OP_MFLO: alu_out = lo;
            default: alu_out = '0;
        endcase
    end

    // One iteration of each long op; acc < dvs keeps the restoring borrow in bit WIDTH.
    assign mul_sum  = {1'b0, acc} + ({1'b0, dvs} & {(WIDTH+1){qr[0]}});
    assign div_sh   = {acc, qr[WIDTH-1]};
    assign div_diff = div_sh - {1'b0, dvs};

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        acc_nx    = acc;
        qr_nx     = qr;
        dvs_nx    = dvs;
        result_nx = result;
        zero_nx   = zero;
        hi_nx     = hi;
        lo_nx     = lo;
        done_nx   = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    cnt_nx = '0;
                    acc_nx = '0;
                    qr_nx  = opA;
                    dvs_nx = opB;
                    if (ALUop == OP_MULT) begin
                        state_nx = MUL;
                    end else if (ALUop == OP_DIV) begin
                        state_nx = DIV;
                    end else begin
                        result_nx = alu_out;
                        zero_nx   = (alu_out == '0);
                        done_nx   = 1'b1;
                    end
                end
            end
            MUL: begin
                acc_nx = mul_sum[WIDTH:1];
                qr_nx  = {mul_sum[0], qr[WIDTH-1:1]};
                cnt_nx = cnt + CNTW'(1);
            end
            DIV: begin
                if (!div_diff[WIDTH]) begin
                    acc_nx = div_diff[WIDTH-1:0];
                    qr_nx  = {qr[WIDTH-2:0], 1'b1};
                end else begin
                    acc_nx = div_sh[WIDTH-1:0];
                    qr_nx  = {qr[WIDTH-2:0], 1'b0};
                end
                cnt_nx = cnt + CNTW'(1);
            end
            default: state_nx = IDLE;
        endcase

        if (busy && last) begin
            state_nx  = IDLE;
            cnt_nx    = '0;
            hi_nx     = acc_nx;
            lo_nx     = qr_nx;
            result_nx = qr_nx;
            zero_nx   = (qr_nx == '0);
            done_nx   = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state  <= IDLE;
            cnt    <= '0;
            result <= '0;
            zero   <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            result <= result_nx;
            zero   <= zero_nx;
            done   <= done_nx;
            hi     <= hi_nx;
            lo     <= lo_nx;
        end
    end

    // NOTE: scratch registers carry no reset; they are always loaded at start before being read.
    always_ff @(posedge CLK) begin
        acc <= acc_nx;
        qr  <= qr_nx;
        dvs <= dvs_nx;
    end

endmodule

// File: tb/tb_alu_seq.sv
// Randomized self-checking bench for alu_seq at WIDTH=32 and WIDTH=8, against
// an arithmetic reference model of the op set and handshake timing.
module tb_alu_seq;

    logic        CLK, RESET;
    logic        start32, zero32, busy32, done32;
    logic [3:0]  op32;
    logic [31:0] a32, b32, res32, hi32, lo32;
    logic        start8, zero8, busy8, done8;
    logic [3:0]  op8;
    logic [7:0]  a8, b8, res8, hi8, lo8;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mres[2], mhi[2], mlo[2];
    logic        mzero[2];

    alu_seq #(.WIDTH(32), .CNTW(6)) dut32 (
        .CLK(CLK), .RESET(RESET), .start(start32), .ALUop(op32), .opA(a32), .opB(b32),
        .result(res32), .zero(zero32), .busy(busy32), .done(done32), .hi(hi32), .lo(lo32)
    );

    alu_seq #(.WIDTH(8), .CNTW(4)) dut8 (
        .CLK(CLK), .RESET(RESET), .start(start8), .ALUop(op8), .opA(a8), .opB(b8),
        .result(res8), .zero(zero8), .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mres[i] = '0; mhi[i] = '0; mlo[i] = '0; mzero[i] = 1'b0;
        end
    endtask

    // Architectural effect of one op, computed with plain arithmetic at width w.
    task automatic model(input int sel, input logic [3:0] op, input logic [31:0] a_in, input logic [31:0] b_in);
        int          w    = (sel != 0) ? 8 : 32;
        logic [31:0] mask = (sel != 0) ? 32'hFF : 32'hFFFF_FFFF;
        logic [31:0] a    = a_in & mask;
        logic [31:0] b    = b_in & mask;
        longint      sa, sb;
        logic [63:0] p;
        logic [31:0] r;
        sa = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
        sb = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
        case (op)
            4'd0:  r = a & b;
            4'd1:  r = a | b;
            4'd2:  r = (a + b) & mask;
            4'd6:  r = (a - b) & mask;
            4'd7:  r = (sa < sb) ? 32'd1 : 32'd0;
            4'd12: r = ~(a | b) & mask;
            4'd8: begin
                p = {32'b0, a} * {32'b0, b};
                mhi[sel] = 32'((p >> w) & {32'b0, mask});
                mlo[sel] = 32'(p & {32'b0, mask});
                r = mlo[sel];
            end
            4'd9: begin
                if (b == 0) begin
                    mlo[sel] = mask;
                    mhi[sel] = a;
                end else begin
                    mlo[sel] = a / b;
                    mhi[sel] = a % b;
                end
                r = mlo[sel];
            end
            4'd10: r = mhi[sel];
            4'd11: r = mlo[sel];
            default: r = '0;
        endcase
        mres[sel]  = r;
        mzero[sel] = (r == 0);
    endtask

    task automatic drive(input int sel, input logic s, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        if (sel != 0) begin
            start8 = s; op8 = op; a8 = a[7:0]; b8 = b[7:0];
        end else begin
            start32 = s; op32 = op; a32 = a; b32 = b;
        end
    endtask

    // Called at a negedge; returns at the negedge of the done cycle so the next call is back-to-back.
    task automatic run(input int sel, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int          w        = (sel != 0) ? 8 : 32;
        bit          long_op  = (op == 4'd8) || (op == 4'd9);
        logic [31:0] prev_res = mres[sel];
        logic [31:0] prev_hi  = mhi[sel];
        logic [31:0] prev_lo  = mlo[sel];
        int          n = 0, busy_cycles = 0, disturbed = 0;
        bit          got_done = 0;
        logic        d, bz;
        logic [31:0] r, h, l;
        logic        z;
        model(sel, op, a, b);
        drive(sel, 1'b1, op, a, b);
        @(posedge CLK);
        #1 drive(sel, 1'b0, 4'($urandom), $urandom, $urandom);
        while (!got_done && n < 100) begin
            @(negedge CLK);
            n++;
            d  = (sel != 0) ? done8 : done32;
            bz = (sel != 0) ? busy8 : busy32;
            r  = (sel != 0) ? {24'b0, res8} : res32;
            h  = (sel != 0) ? {24'b0, hi8}  : hi32;
            l  = (sel != 0) ? {24'b0, lo8}  : lo32;
            z  = (sel != 0) ? zero8 : zero32;
            if (d) begin
                got_done = 1;
                check("busy_at_done", bz, 1'b0);
                drive(sel, 1'b0, 4'($urandom), $urandom, $urandom);
            end else begin
                if (bz) busy_cycles++;
                if (r !== prev_res || h !== prev_hi || l !== prev_lo) disturbed++;
                // A start arriving during busy must be ignored.
                drive(sel, 1'($urandom_range(0, 1)), 4'($urandom), $urandom, $urandom);
            end
        end
        check("latency", n, long_op ? w + 1 : 1);
        check("busy_cycles", busy_cycles, long_op ? w : 0);
        check("hold_during_busy", disturbed, 0);
        check("result", r, mres[sel]);
        check("zero", z, mzero[sel]);
        check("hi", h, mhi[sel]);
        check("lo", l, mlo[sel]);
    endtask

    task automatic check_reset_state();
        check("rst_result32", res32, 0);
        check("rst_zero32", zero32, 0);
        check("rst_busy32", busy32, 0);
        check("rst_done32", done32, 0);
        check("rst_hi32", hi32, 0);
        check("rst_lo32", lo32, 0);
        check("rst_busy8", busy8, 0);
        check("rst_hi8", hi8, 0);
    endtask

    logic [3:0] op_list[10] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12, 4'd8, 4'd9, 4'd10, 4'd11};

    initial begin
        RESET = 1'b1;
        drive(0, 1'b0, 4'd0, 0, 0);
        drive(1, 1'b0, 4'd0, 0, 0);
        model_reset();
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        check_reset_state();

        run(0, 4'd2, 32'd5, 32'd7);
        run(0, 4'd6, 32'd3, 32'd3);
        run(0, 4'd7, 32'hFFFF_FFFF, 32'd1);
        run(0, 4'd7, 32'd1, 32'hFFFF_FFFF);
        run(0, 4'd2, 32'hFFFF_FFFF, 32'd1);
        run(0, 4'd8, 32'hFFFF_FFFF, 32'd2);
        run(0, 4'd10, 32'd0, 32'd0);
        run(0, 4'd11, 32'd0, 32'd0);
        run(0, 4'd9, 32'd100, 32'd7);
        run(0, 4'd9, 32'd5, 32'd0);
        run(0, 4'd5, 32'h1234, 32'h5678);

        // Reset during the 10th busy cycle of a MULTU aborts it.
        drive(0, 1'b1, 4'd8, 32'hDEAD_BEEF, 32'h1234_5678);
        @(posedge CLK);
        #1 drive(0, 1'b0, 4'd2, 0, 0);
        for (int i = 1; i <= 10; i++) begin
            @(negedge CLK);
            check("pre_reset_busy", busy32, 1'b1);
        end
        RESET = 1'b1;
        @(posedge CLK);
        #1 RESET = 1'b0;
        model_reset();
        @(negedge CLK);
        check_reset_state();
        run(0, 4'd2, 32'd1, 32'd1);

        run(1, 4'd8, 32'hFF, 32'hFF);
        run(1, 4'd5, 32'h12, 32'h34);
        run(1, 4'd9, 32'hC8, 32'h0D);
        run(1, 4'd9, 32'h2A, 32'h00);
        run(1, 4'd10, 32'd0, 32'd0);

        for (int i = 0; i < 80; i++) begin
            int          sel = int'($urandom_range(0, 1));
            logic [3:0]  op  = ($urandom_range(0, 9) == 0) ? 4'($urandom) : op_list[$urandom_range(0, 9)];
            logic [31:0] a   = $urandom;
            logic [31:0] b   = ($urandom_range(0, 7) == 0) ? 32'd0 :
                               ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
            run(sel, op, a, b);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
